halloween_cmd_decoder: RTL and testbench

Receive end of the decoration opcode stream: accepts the 4-bit opcodes produced by the opcode sequencer and turns them into actuator drive signals for the prop. Opcodes are a 2-bit class in cmd[3:2] and a 2-bit value in cmd[1:0]. The block tracks power state, holds the current colour, and runs timed sound and movement/effect channels. It sits between the sequencer's output and the prop's LED, audio and motor drivers.

---
 rtl/halloween_cmd_decoder_if.sv | 25 ++
 rtl/halloween_cmd_decoder.sv | 159 +++++++++++++++
 tb/tb_halloween_cmd_decoder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/halloween_cmd_decoder_if.sv
// Opcode bus from the decoration sequencer plus the actuator drive outputs.
interface halloween_cmd_decoder_if;
  logic       cmd_valid;
  logic [3:0] cmd;
  logic       powered;
  logic [1:0] color;
  logic       sound_on;
  logic [1:0] sound_sel;
  logic       effect_on;
  logic [1:0] effect_sel;
  logic       err;
  logic [7:0] cmd_count;

  // Sequencer side: drives opcodes, observes the prop state.
  modport master (
    output cmd_valid, cmd,
    input  powered, color, sound_on, sound_sel, effect_on, effect_sel, err, cmd_count
  );

  // Decoder side.
  modport slave (
    input  cmd_valid, cmd,
    output powered, color, sound_on, sound_sel, effect_on, effect_sel, err, cmd_count
  );
endinterface

// File: rtl/halloween_cmd_decoder.sv
// Decoration opcode decoder: power FSM, colour register, and two timed
// actuator channels (sound, movement/effect) with retriggerable timers.

// One timed channel: selector register plus a 16-bit down-counter.
// Load and clear are mutually exclusive from the decoder.
module halloween_chan_timer #(
  parameter int unsigned CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clr,
  input  logic [1:0] sel_in,
  output logic       on,
  output logic [1:0] sel
);
  localparam logic [15:0] LOAD_VAL = 16'(CYCLES);

  logic [15:0] tmr;

  // Reload on trigger (even on the last active cycle), else count down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
      sel <= '0;
    end else if (clr) begin
      tmr <= '0;
      sel <= '0;
    end else if (load) begin
      tmr <= LOAD_VAL;
      sel <= sel_in;
    end else if (tmr != 16'd0) begin
      tmr <= tmr - 16'd1;
    end
  end

  assign on = (tmr != 16'd0);
endmodule

module halloween_cmd_decoder #(
  parameter int unsigned SOUND_CYCLES  = 16,
  parameter int unsigned EFFECT_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  halloween_cmd_decoder_if.slave  bus
);
  typedef enum logic { ST_OFF = 1'b0, ST_ON = 1'b1 } state_t;

  localparam logic [1:0] CLS_PWR = 2'b00;
  localparam logic [1:0] CLS_COL = 2'b01;
  localparam logic [1:0] CLS_SND = 2'b10;

  state_t     state, state_d;
  logic [1:0] cls, val;
  logic       legal;
  logic       err_d, count_en, col_ld, snd_ld, eff_ld, chan_clr;
  logic [1:0] color_q;
  logic       err_q;
  logic [7:0] cnt_q;

  assign cls = bus.cmd[3:2];
  assign val = bus.cmd[1:0];

  // Power class only has ON/RESET; other classes reject value 11.
  always_comb begin
    legal = 1'b0;
    if (cls == CLS_PWR) legal = (val[1] == 1'b0);
    else                legal = (val != 2'b11);
  end

  // Next-state and per-opcode actions.  While OFF only power opcodes count;
  // any other legal opcode is ignored and flagged.
  always_comb begin
    state_d  = state;
    err_d    = 1'b0;
    count_en = 1'b0;
    col_ld   = 1'b0;
    snd_ld   = 1'b0;
    eff_ld   = 1'b0;
    chan_clr = 1'b0;
    if (bus.cmd_valid) begin
      if (!legal) begin
        err_d = 1'b1;
      end else begin
        case (state)
          ST_OFF: begin
            if (cls == CLS_PWR) begin
              count_en = 1'b1;
              if (val == 2'b00) state_d = ST_ON;
            end else begin
              err_d = 1'b1;
            end
          end
          ST_ON: begin
            count_en = 1'b1;
            case (cls)
              CLS_PWR: begin
                if (val == 2'b01) begin
                  state_d  = ST_OFF;
                  chan_clr = 1'b1;
                end
              end
              CLS_COL: col_ld = 1'b1;
              CLS_SND: snd_ld = 1'b1;
              default: eff_ld = 1'b1;
            endcase
          end
          default: state_d = ST_OFF;
        endcase
      end
    end
  end

  // Power state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_OFF;
    else        state <= state_d;
  end

  // Colour, error pulse and accepted-opcode counter (wraps naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_q <= 2'b00;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      err_q <= err_d;
      if (chan_clr)    color_q <= 2'b00;
      else if (col_ld) color_q <= val;
      if (count_en)    cnt_q   <= cnt_q + 8'd1;
    end
  end

  halloween_chan_timer #(.CYCLES(SOUND_CYCLES)) u_sound (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (snd_ld),
    .clr    (chan_clr),
    .sel_in (val),
    .on     (bus.sound_on),
    .sel    (bus.sound_sel)
  );

  halloween_chan_timer #(.CYCLES(EFFECT_CYCLES)) u_effect (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (eff_ld),
    .clr    (chan_clr),
    .sel_in (val),
    .on     (bus.effect_on),
    .sel    (bus.effect_sel)
  );

  assign bus.powered   = (state == ST_ON);
  assign bus.color     = color_q;
  assign bus.err       = err_q;
  assign bus.cmd_count = cnt_q;
endmodule

// File: tb/tb_halloween_cmd_decoder.sv
// Bench for halloween_cmd_decoder: edge-stamped behavioural model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_halloween_cmd_decoder;
  localparam int SND = 16;
  localparam int EFF = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  halloween_cmd_decoder_if bus ();

  halloween_cmd_decoder #(.SOUND_CYCLES(SND), .EFFECT_CYCLES(EFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: channels are represented by the edge index of their last trigger;
  // a channel is active for the SND/EFF cycles following that edge.
  int         cyc    = 0;
  int         s_edge = -100000;
  int         e_edge = -100000;
  logic       m_pow  = 1'b0;
  logic [1:0] m_col  = 2'b00;
  logic [1:0] m_ssel = 2'b00;
  logic [1:0] m_esel = 2'b00;
  logic       m_err  = 1'b0;
  logic [7:0] m_cnt  = 8'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_edge <= -100000;
      e_edge <= -100000;
      m_pow  <= 1'b0;
      m_col  <= 2'b00;
      m_ssel <= 2'b00;
      m_esel <= 2'b00;
      m_err  <= 1'b0;
      m_cnt  <= 8'd0;
    end else begin
      cyc   <= cyc + 1;
      m_err <= 1'b0;
      if (bus.cmd_valid) begin
        case (bus.cmd)
          4'h0: begin m_pow <= 1'b1; m_cnt <= m_cnt + 8'd1; end
          4'h1: begin
            m_cnt <= m_cnt + 8'd1;
            if (m_pow) begin
              m_pow <= 1'b0; m_col <= 2'b00; m_ssel <= 2'b00; m_esel <= 2'b00;
              s_edge <= -100000; e_edge <= -100000;
            end
          end
          4'h4, 4'h5, 4'h6:
            if (m_pow) begin m_col <= bus.cmd[1:0]; m_cnt <= m_cnt + 8'd1; end
            else m_err <= 1'b1;
          4'h8, 4'h9, 4'hA:
            if (m_pow) begin m_ssel <= bus.cmd[1:0]; s_edge <= cyc; m_cnt <= m_cnt + 8'd1; end
            else m_err <= 1'b1;
          4'hC, 4'hD, 4'hE:
            if (m_pow) begin m_esel <= bus.cmd[1:0]; e_edge <= cyc; m_cnt <= m_cnt + 8'd1; end
            else m_err <= 1'b1;
          default: m_err <= 1'b1;
        endcase
      end
    end
  end

  // Active-cycle counters used by the duration checks.
  int snd_hi = 0;
  int eff_hi = 0;
  always @(negedge clk) begin
    if (bus.sound_on)  snd_hi <= snd_hi + 1;
    if (bus.effect_on) eff_hi <= eff_hi + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic [17:0] act, exp;
    logic        s_on, e_on;
    s_on = ((cyc - s_edge) <= SND);
    e_on = ((cyc - e_edge) <= EFF);
    act = {bus.powered, bus.color, bus.sound_on, bus.sound_sel, bus.effect_on,
           bus.effect_sel, bus.err, bus.cmd_count};
    exp = {m_pow, m_col, s_on, m_ssel, e_on, m_esel, m_err, m_cnt};
    check("cycle_model", {14'd0, act}, {14'd0, exp});
  endtask

  // Drive one opcode for one edge; returns 2 time units after that edge.
  task automatic send(input logic [3:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  logic [3:0] illegal_ops [5] = '{4'h2, 4'h3, 4'h7, 4'hB, 4'hF};

  initial begin
    int s0, e0;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 4'h0;

    fork
      forever begin @(negedge clk); compare_cycle(); end
    join_none

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    check("rst_powered", {31'd0, bus.powered}, 32'd0);
    check("rst_count",   {24'd0, bus.cmd_count}, 32'd0);
    check("rst_outs",    {24'd0, bus.color, bus.sound_on, bus.sound_sel, bus.effect_on, bus.effect_sel, bus.err}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // ON, PURPLE, BOO, FOG back to back.
    s0 = snd_hi; e0 = eff_hi;
    send(4'h0); send(4'h5); send(4'hA); send(4'hE);
    check("t1_powered", {31'd0, bus.powered}, 32'd1);
    check("t1_color",   {30'd0, bus.color}, 32'd1);
    idle(40);
    check("t1_snd_len", snd_hi - s0, 32'd16);
    check("t1_eff_len", eff_hi - e0, 32'd32);
    check("t1_sels",    {28'd0, bus.sound_sel, bus.effect_sel}, 32'hA);
    check("t1_count",   {24'd0, bus.cmd_count}, 32'd4);

    // RESET opcode to OFF, then colour/sound are ignored with err pulses.
    send(4'h1);
    check("t2_off", {31'd0, bus.powered}, 32'd0);
    send(4'h6);
    check("t2_err1", {31'd0, bus.err}, 32'd1);
    send(4'h8);
    check("t2_err2", {31'd0, bus.err}, 32'd1);
    idle(1);
    check("t2_err_clr", {31'd0, bus.err}, 32'd0);
    check("t2_state", {28'd0, bus.color, bus.sound_on, bus.powered}, 32'd0);
    check("t2_count", {24'd0, bus.cmd_count}, 32'd5);

    // Sound retrigger: CACKLING at N, SCREAMING at N+10.
    send(4'h0);
    send(4'h9);
    s0 = snd_hi;
    idle(9);
    check("t3_sel_a", {30'd0, bus.sound_sel}, 32'd1);
    send(4'h8);
    check("t3_sel_b", {30'd0, bus.sound_sel}, 32'd0);
    idle(30);
    check("t3_snd_len", snd_hi - s0, 32'd26);
    check("t3_count", {24'd0, bus.cmd_count}, 32'd8);

    // Illegal opcodes while ON.
    foreach (illegal_ops[i]) begin
      send(illegal_ops[i]);
      check("t4_err", {31'd0, bus.err}, 32'd1);
    end
    check("t4_count", {24'd0, bus.cmd_count}, 32'd8);
    check("t4_powered", {31'd0, bus.powered}, 32'd1);

    // RESET opcode while MOVEJAW active.
    send(4'h6); send(4'hD);
    idle(3);
    check("t5_eff_on", {31'd0, bus.effect_on}, 32'd1);
    send(4'h1);
    check("t5_clear", {26'd0, bus.powered, bus.effect_on, bus.effect_sel, bus.color}, 32'd0);
    check("t5_count", {24'd0, bus.cmd_count}, 32'd11);

    // Async reset mid-effect.
    send(4'h0); send(4'hD);
    idle(3);
    rst_n = 1'b0;
    #1;
    check("t5_arst", {18'd0, bus.powered, bus.color, bus.sound_on, bus.sound_sel,
                      bus.effect_on, bus.effect_sel, bus.err, bus.cmd_count}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    idle(40);
    check("t5_no_resid", {31'd0, bus.effect_on}, 32'd0);

    // 256 ON opcodes wrap the counter.
    repeat (256) send(4'h0);
    check("t6_wrap", {24'd0, bus.cmd_count}, 32'd0);
    check("t6_powered", {31'd0, bus.powered}, 32'd1);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
